// File: rtl/baud_tick_generator.sv
// baud_tick_generator
//   Runtime-programmable oversampling tick generator for the UART TX/RX cores.
//   A fractional divisor (div_int + div_frac / 2^FRAC_W) sets the os_tick rate.
//   os_tick fires at OVERSAMPLE x baud. bit_tick fires once every OVERSAMPLE
//   os_ticks and always coincides with an os_tick.
//
// Ports
//   clk, rst      system clock; asynchronous active-high reset
//   enable        1 = run, 0 = hold counters (ticks forced low)
//   div_int       integer divisor to load (0 is treated as 1)
//   div_frac      fractional divisor to load, in units of 2^-FRAC_W
//   div_load      strobe: capture div_int/div_frac
//                 (deferred to the period boundary while running)
//   resync        strobe: restart the period and the oversample phase
//   os_tick       registered one-cycle oversample tick
//   bit_tick      registered one-cycle bit tick
//   os_phase      registered oversample index (0 .. OVERSAMPLE-1)
//   load_pending  a captured divisor is waiting for the next period boundary
module baud_tick_generator #(
  parameter int unsigned DIV_W            = 16,
  parameter int unsigned FRAC_W           = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 78,
  parameter int unsigned DEFAULT_DIV_FRAC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  input  logic                          resync,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          load_pending
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]   OS_MAX   = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEFAULT_DIV_INT);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_DIV_FRAC);

  // A zero divisor means a 1-cycle period. The extra bit lets a
  // fractional carry on a full-scale divisor fit in the result.
  function automatic logic [DIV_W:0] eff_period(input logic [DIV_W-1:0] d);
    return (d == '0) ? (DIV_W+1)'(1) : {1'b0, d};
  endfunction

  logic [DIV_W-1:0]  div_int_q,  div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [DIV_W-1:0]  sh_int_q,   sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q,  sh_frac_d;
  logic              load_pending_q, load_pending_d;
  logic [DIV_W-1:0]  cnt_q,      cnt_d;
  logic [DIV_W:0]    period_q,   period_d;
  logic [FRAC_W-1:0] acc_q,      acc_d;
  logic [OS_W-1:0]   os_cnt_q,   os_cnt_d;
  logic              os_tick_q,  os_tick_d;
  logic              bit_tick_q, bit_tick_d;

  logic              terminal;
  logic [DIV_W-1:0]  use_int;
  logic [FRAC_W-1:0] use_frac;
  logic [DIV_W-1:0]  rs_int;
  logic [FRAC_W-1:0] rs_frac;
  logic [FRAC_W:0]   acc_sum;

  always_comb begin
    // The divisor that governs the period about to begin. A pending shadow
    // value replaces the active one at a boundary or on resync.
    use_int  = load_pending_q ? sh_int_q  : div_int_q;
    use_frac = load_pending_q ? sh_frac_q : div_frac_q;

    // A load strobe that coincides with resync is applied at once.
    rs_int   = div_load ? div_int  : use_int;
    rs_frac  = div_load ? div_frac : use_frac;

    terminal = enable && ({1'b0, cnt_q} == (period_q - (DIV_W+1)'(1)));
    acc_sum  = {1'b0, acc_q} + {1'b0, use_frac};
  end

  always_comb begin
    div_int_d      = div_int_q;
    div_frac_d     = div_frac_q;
    sh_int_d       = sh_int_q;
    sh_frac_d      = sh_frac_q;
    load_pending_d = load_pending_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    acc_d          = acc_q;
    os_cnt_d       = os_cnt_q;
    os_tick_d      = 1'b0;
    bit_tick_d     = 1'b0;

    if (resync) begin
      // Resync wins over a coincident terminal cycle, so that tick is dropped.
      div_int_d      = rs_int;
      div_frac_d     = rs_frac;
      load_pending_d = 1'b0;
      period_d       = eff_period(rs_int);
      cnt_d          = '0;
      acc_d          = '0;
      os_cnt_d       = '0;
    end else if (!enable) begin
      // While idle, a load needs no glitch protection and takes effect at once.
      if (div_load) begin
        div_int_d      = div_int;
        div_frac_d     = div_frac;
        load_pending_d = 1'b0;
        period_d       = eff_period(div_int);
        cnt_d          = '0;
        acc_d          = '0;
      end
    end else begin
      if (terminal) begin
        cnt_d          = '0;
        os_tick_d      = 1'b1;
        div_int_d      = use_int;
        div_frac_d     = use_frac;
        load_pending_d = 1'b0;
        acc_d          = acc_sum[FRAC_W-1:0];
        // The fractional carry stretches the next period by one cycle.
        period_d       = eff_period(use_int) + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
        os_cnt_d       = (os_cnt_q == OS_MAX) ? '0 : os_cnt_q + OS_W'(1);
        bit_tick_d     = (os_cnt_q == OS_MAX);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      // A load in a terminal cycle is captured after the old shadow moves to
      // the active registers. It then waits for the following boundary.
      if (div_load) begin
        sh_int_d       = div_int;
        sh_frac_d      = div_frac;
        load_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_int_q      <= DEF_INT;
      div_frac_q     <= DEF_FRAC;
      sh_int_q       <= DEF_INT;
      sh_frac_q      <= DEF_FRAC;
      load_pending_q <= 1'b0;
      cnt_q          <= '0;
      period_q       <= eff_period(DEF_INT);
      acc_q          <= '0;
      os_cnt_q       <= '0;
      os_tick_q      <= 1'b0;
      bit_tick_q     <= 1'b0;
    end else begin
      div_int_q      <= div_int_d;
      div_frac_q     <= div_frac_d;
      sh_int_q       <= sh_int_d;
      sh_frac_q      <= sh_frac_d;
      load_pending_q <= load_pending_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      acc_q          <= acc_d;
      os_cnt_q       <= os_cnt_d;
      os_tick_q      <= os_tick_d;
      bit_tick_q     <= bit_tick_d;
    end
  end

  assign os_tick      = os_tick_q;
  assign bit_tick     = bit_tick_q;
  assign os_phase     = os_cnt_q;
  assign load_pending = load_pending_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// tb_baud_tick_generator
//   Directed bench for baud_tick_generator using its default parameters
//   (div 78 + 2/16, OVERSAMPLE 16).
//   A closed-form reference model predicts every tick as an absolute
//   enabled-cycle offset from the last restart point (epoch):
//     T_j = P0 + (j-1)*I + floor((A + (j-1)*F) / 16)
//   Here P0 is the first period, A the accumulator at the epoch, I/F the divisor.
module tb_baud_tick_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] div_int = 16'd0;
  logic [3:0]  div_frac = 4'd0;
  logic        div_load = 1'b0;
  logic        resync = 1'b0;
  logic        os_tick;
  logic        bit_tick;
  logic [3:0]  os_phase;
  logic        load_pending;

  baud_tick_generator #(
    .DIV_W(16),
    .FRAC_W(4),
    .OVERSAMPLE(16),
    .DEFAULT_DIV_INT(78),
    .DEFAULT_DIV_FRAC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .div_int(div_int),
    .div_frac(div_frac),
    .div_load(div_load),
    .resync(resync),
    .os_tick(os_tick),
    .bit_tick(bit_tick),
    .os_phase(os_phase),
    .load_pending(load_pending)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int m_i = 78, m_f = 2, m_si = 78, m_sf = 2;
  bit m_pend = 1'b0;
  int m_e = 0, m_j = 0, m_a = 0, m_p0 = 78, m_ticks = 0;
  bit m_os = 1'b0, m_bit = 1'b0;

  function automatic int effi(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_i = 78; m_f = 2; m_pend = 0;
      m_e = 0; m_j = 0; m_a = 0; m_p0 = 78; m_ticks = 0;
      m_os = 0; m_bit = 0;
    end else begin
      m_os = 0;
      m_bit = 0;
      if (resync) begin
        if (div_load) begin
          m_i = int'(div_int); m_f = int'(div_frac);
        end else if (m_pend) begin
          m_i = m_si; m_f = m_sf;
        end
        m_pend = 0;
        m_e = 0; m_j = 0; m_a = 0; m_p0 = effi(m_i); m_ticks = 0;
      end else if (!enable) begin
        if (div_load) begin
          m_i = int'(div_int); m_f = int'(div_frac); m_pend = 0;
          m_e = 0; m_j = 0; m_a = 0; m_p0 = effi(m_i);
        end
      end else begin
        m_e++;
        if (m_e == m_p0 + m_j * effi(m_i) + (m_a + m_j * m_f) / 16) begin
          int acc_before;
          int s;
          acc_before = (m_a + m_j * m_f) % 16;
          m_j++;
          m_ticks++;
          m_os = 1;
          m_bit = (m_ticks % 16 == 0);
          if (m_pend) begin
            m_i = m_si; m_f = m_sf; m_pend = 0;
            s = acc_before + m_f;
            m_e = 0; m_j = 0; m_a = s % 16; m_p0 = effi(m_i) + s / 16;
          end
        end
        if (div_load) begin
          m_si = int'(div_int); m_sf = int'(div_frac); m_pend = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("os_tick", int'(os_tick), int'(m_os));
    chk("bit_tick", int'(bit_tick), int'(m_bit));
    chk("os_phase", int'(os_phase), m_ticks % 16);
    chk("load_pending", int'(load_pending), int'(m_pend));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_os(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (os_tick) begin
        at = cyc;
        return;
      end
    end
    chk("os_tick_timeout", 0, 1);
  endtask

  task automatic wait_bit(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bit_tick) begin
        at = cyc;
        return;
      end
    end
    chk("bit_tick_timeout", 0, 1);
  endtask

  task automatic pulse_load(input int i, input int f);
    div_int = 16'(i);
    div_frac = 4'(f);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  int t[18];
  int rel, a, b, r, s, n, prev;

  initial begin
    // 1: defaults, fractional spacing and bit rate
    repeat (3) @(negedge clk);
    chk("reset_os_tick", int'(os_tick), 0);
    chk("reset_os_phase", int'(os_phase), 0);
    rst = 1'b0;
    rel = cyc;
    for (int k = 1; k <= 17; k++) begin
      wait_os(100, t[k]);
      if (k == 16) begin
        chk("t1_bit_at_16th", int'(bit_tick), 1);
        chk("t1_phase_wrap", int'(os_phase), 0);
      end
    end
    chk("t1_p1", t[1] - rel, 78);
    chk("t1_p8", t[8] - t[7], 78);
    chk("t1_p9", t[9] - t[8], 79);
    chk("t1_p10", t[10] - t[9], 78);
    chk("t1_p17", t[17] - t[16], 79);
    chk("t1_sum_p2_p9", t[9] - t[1], 625);
    chk("t1_first_bit", t[16] - rel, 1249);
    wait_bit(1400, b);
    chk("t1_bit_spacing", b - t[16], 1250);

    // 2: deferred load completes the current period
    wait_os(100, a);
    chk("t2_p33", a - b, 79);
    repeat (10) @(negedge clk);
    pulse_load(4, 0);
    chk("t2_pending_set", int'(load_pending), 1);
    wait_os(100, prev);
    chk("t2_old_period", prev - a, 78);
    chk("t2_pending_clear", int'(load_pending), 0);
    for (int k = 0; k < 3; k++) begin
      wait_os(20, a);
      chk("t2_new_period", a - prev, 4);
      prev = a;
    end

    // 3: resync realigns the phase
    pulse_load(10, 0);
    wait_os(20, a);
    wait_os(20, a);
    repeat (5) @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    r = cyc;
    chk("t3_phase_after_resync", int'(os_phase), 0);
    wait_os(30, a);
    chk("t3_first_after_resync", a - r, 10);
    chk("t3_phase_first", int'(os_phase), 1);
    wait_bit(200, b);
    chk("t3_bit_after_resync", b - r, 160);

    // 4: hold mid-period, then resume
    enable = 1'b0;
    pulse_load(78, 2);
    chk("t4_idle_load_no_pending", int'(load_pending), 0);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    enable = 1'b0;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (os_tick) n++;
    end
    chk("t4_no_tick_in_hold", n, 0);
    enable = 1'b1;
    s = cyc;
    wait_os(100, a);
    chk("t4_resume", a - s, 48);

    // 5: zero divisor means tick every cycle
    enable = 1'b0;
    pulse_load(0, 0);
    enable = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (os_tick) n++;
    end
    chk("t5_every_cycle", n, 20);
    wait_bit(40, a);
    wait_bit(40, b);
    chk("t5_bit_spacing", b - a, 16);

    // 6: async reset with a pending load
    enable = 1'b0;
    pulse_load(78, 2);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    pulse_load(5, 0);
    chk("t6_pending_before_rst", int'(load_pending), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_os_tick", int'(os_tick), 0);
    chk("t6_async_bit_tick", int'(bit_tick), 0);
    chk("t6_async_phase", int'(os_phase), 0);
    chk("t6_async_pending", int'(load_pending), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    wait_os(100, a);
    chk("t6_first_after_rst", a - rel, 78);
    wait_os(100, b);
    chk("t6_load_discarded", b - a, 78);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
